// File: rtl/riscv_mon_pkg.sv
// Shared types, default parameters and helpers for the RISC-V result monitor.
package riscv_mon_pkg;

  localparam int unsigned ADDR_W_DEF      = 30;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned NUM_CHECKS_DEF  = 14;
  localparam int unsigned BASE_ADDR_DEF   = 0;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned ERR_W_DEF       = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 50000;
  localparam int unsigned BYTE_SWAP_DEF   = 1;

  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned SAT_W      = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPORT = 2'd2
  } mon_state_e;

  // Reverse the lowest nbytes bytes of x; the result sits in the low nbytes bytes.
  function automatic logic [MAX_DATA_W-1:0] byte_swap(input logic [MAX_DATA_W-1:0] x,
                                                       input int unsigned nbytes);
    logic [MAX_DATA_W-1:0] r;
    r = {<<8{x}};
    return r >> (8 * (MAX_DATA_W / 8 - nbytes));
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned w);
    logic [SAT_W-1:0] lim;
    lim = (SAT_W'(1) << w) - SAT_W'(1);
    return (v >= lim) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/riscv_result_monitor_if.sv
// Snooped core-side signals: data-memory write port, pipeline events and fetch address.
interface riscv_result_monitor_if
  import riscv_mon_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              stall;
  logic              flush;
  logic              is_branch;
  logic [ADDR_W-1:0] I_addr;

  modport master (output wen, addr, data, stall, flush, is_branch, I_addr);
  modport slave  (input  wen, addr, data, stall, flush, is_branch, I_addr);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter
  import riscv_mon_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= W'(sat_inc(SAT_W'(q), W));
  end

endmodule

// File: rtl/riscv_result_monitor.sv
// Checks core result writes against a loadable expected table and
// collects cycle/stall/flush/branch/fetch statistics until finish.
module riscv_result_monitor
  import riscv_mon_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned NUM_CHECKS  = NUM_CHECKS_DEF,
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned ERR_W       = ERR_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned BYTE_SWAP   = BYTE_SWAP_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  riscv_result_monitor_if.slave         bus,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_CHECKS)-1:0] cfg_idx,
  input  logic [DATA_W-1:0]             cfg_data,
  output logic [1:0]                    state_o,
  output logic [ERR_W-1:0]              error_num,
  output logic [CNT_W-1:0]              duration,
  output logic [CNT_W-1:0]              stall_cycles,
  output logic [CNT_W-1:0]              flush_count,
  output logic [CNT_W-1:0]              branch_count,
  output logic [CNT_W-1:0]              instr_count,
  output logic                          finish,
  output logic                          pass,
  output logic                          timeout
);

  mon_state_e              state, state_n;
  logic [NUM_CHECKS-1:0]   seen, seen_n;
  logic [ERR_W-1:0]        err_n;
  logic [ERR_W:0]          err_sum;
  logic                    finish_n, pass_n, timeout_n;
  logic                    wen_q, wr_ev, in_check, instr_inc;
  logic [ADDR_W-1:0]       prev_iaddr;
  logic [DATA_W-1:0]       wdata;
  logic [DATA_W-1:0]       exp_tbl [NUM_CHECKS];

  assign wdata = (BYTE_SWAP != 0) ? DATA_W'(byte_swap(MAX_DATA_W'(bus.data), DATA_W / 8))
                                  : DATA_W'(bus.data);
  // Rising edge of wen: a write held across stalls is seen once.
  assign wr_ev     = bus.wen && !wen_q;
  assign in_check  = (state == ST_CHECK);
  assign instr_inc = in_check && !bus.stall && (bus.I_addr != prev_iaddr);
  assign state_o   = state;

  // Expected table is deliberately not reset so it survives test restarts.
  always_ff @(posedge clk) begin
    if (cfg_we && (32'(cfg_idx) < NUM_CHECKS)) exp_tbl[cfg_idx] <= cfg_data;
  end

  always_comb begin
    state_n   = state;
    seen_n    = seen;
    err_n     = error_num;
    err_sum   = '0;
    finish_n  = finish;
    pass_n    = pass;
    timeout_n = timeout;
    unique case (state)
      ST_IDLE: begin
        if (wr_ev && (bus.addr == ADDR_W'(BASE_ADDR)) && (wdata == exp_tbl[0])) begin
          state_n = ST_CHECK;
          err_n   = '0;
          seen_n  = NUM_CHECKS'(1);
        end
      end
      ST_CHECK: begin
        for (int unsigned k = 1; k < NUM_CHECKS; k++) begin
          if (wr_ev && (bus.addr == ADDR_W'(BASE_ADDR + k)) && !seen[k]) begin
            seen_n[k] = 1'b1;
            if (wdata != exp_tbl[k]) err_n = ERR_W'(sat_inc(SAT_W'(err_n), ERR_W));
          end
        end
        // A hit landing on the timeout cycle is scored before the timeout is considered.
        if (&seen_n) begin
          state_n   = ST_REPORT;
          finish_n  = 1'b1;
          timeout_n = 1'b0;
          pass_n    = (err_n == '0);
        end else if (32'(duration) == 32'(TIMEOUT_CYC - 1)) begin
          state_n   = ST_REPORT;
          finish_n  = 1'b1;
          timeout_n = 1'b1;
          pass_n    = 1'b0;
          err_sum   = {1'b0, err_n} + (ERR_W + 1)'($countones(~seen_n));
          err_n     = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      seen       <= '0;
      error_num  <= '1;
      finish     <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      wen_q      <= 1'b0;
      prev_iaddr <= '0;
    end else begin
      state     <= state_n;
      seen      <= seen_n;
      error_num <= err_n;
      finish    <= finish_n;
      pass      <= pass_n;
      timeout   <= timeout_n;
      wen_q     <= bus.wen;
      if (instr_inc) prev_iaddr <= bus.I_addr;
    end
  end

  sat_counter #(.W(CNT_W)) u_duration (
    .clk(clk), .rst(rst), .inc(in_check), .clr(state == ST_IDLE), .q(duration));
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .inc(in_check && bus.stall), .clr(state == ST_IDLE), .q(stall_cycles));
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .rst(rst), .inc(in_check && bus.flush), .clr(state == ST_IDLE), .q(flush_count));
  sat_counter #(.W(CNT_W)) u_branch (
    .clk(clk), .rst(rst), .inc(in_check && bus.is_branch), .clr(state == ST_IDLE), .q(branch_count));
  sat_counter #(.W(CNT_W)) u_instr (
    .clk(clk), .rst(rst), .inc(instr_inc), .clr(state == ST_IDLE), .q(instr_count));

endmodule

// File: doc/riscv_result_monitor.md
Name: riscv_result_monitor

Overview:
- Synthesizable, parametrised result checker and performance monitor for the RISC-V core under test.
- Snoops the data-memory write port.
- Compares writes that hit a window of check addresses against a runtime-loadable expected-value table.
- Counts errors, cycles, stalls, flushes, branches and retired fetch addresses, then raises finish/pass.
- Sits beside the core in the test top; replaces hard-coded answer lists with a table of NUM_CHECKS entries plus a timeout.

Parameters:
ADDR_W, 30, word-address width of the data port and the fetch port
DATA_W, 32, data width; must be a multiple of 8
NUM_CHECKS, 14, number of check ports; port k is at word address BASE_ADDR+k
BASE_ADDR, 0, word address of check port 0 (the start port)
CNT_W, 16, width of the duration and performance counters
ERR_W, 8, width of error_num
TIMEOUT_CYC, 50000, CHECK cycles allowed before a forced report
BYTE_SWAP, 1, 1 = reverse byte order of data before comparing (little-endian bus)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
wen  in  1  data-memory write enable
addr  in  ADDR_W  data-memory word address
data  in  DATA_W  data-memory write data
stall  in  1  core memory stall this cycle
flush  in  1  pipeline flush this cycle
is_branch  in  1  branch instruction resolved this cycle
I_addr  in  ADDR_W  instruction fetch address
cfg_we  in  1  expected-table write strobe
cfg_idx  in  clog2(NUM_CHECKS)  table index
cfg_data  in  DATA_W  expected value
state_o  out  2  0 IDLE, 1 CHECK, 2 REPORT
error_num  out  ERR_W  error count
duration  out  CNT_W  cycles spent in CHECK
stall_cycles  out  CNT_W  stall count
flush_count  out  CNT_W  flush count
branch_count  out  CNT_W  branch count
instr_count  out  CNT_W  fetch-address change count
finish  out  1  high in REPORT
pass  out  1  finish && error_num==0 && !timeout
timeout  out  1  REPORT was entered by timeout

Behaviour:
- Reset (async, rst low): state IDLE; error_num = all ones; all counters 0; finish, pass and timeout 0; seen bitmap 0; write-edge flag 0; prev_iaddr 0.
- Expected table is not reset. cfg_we writes the entry on the next clock edge in any state; an index >= NUM_CHECKS is ignored.
- wdata = byte-reversed data when BYTE_SWAP=1, otherwise data.
- Write event:
  - wr_ev = wen && !wen_q, where wen_q is wen registered.
  - A write held high across stall cycles counts exactly once.
  - A new write is recognised only after wen has been low for at least one cycle.
- hit_k = wr_ev && addr == BASE_ADDR+k. The address compare is full width; no aliasing.
- IDLE:
  - Outputs hold their reset values; error_num stays all ones.
  - hit_0 with wdata == exp[0]: next cycle CHECK, error_num 0, seen[0] set.
  - hit_0 with a mismatch: stay in IDLE.
- CHECK:
  - duration increments each cycle.
  - stall, flush and is_branch increment their counters.
  - instr_count increments when I_addr != prev_iaddr and !stall; prev_iaddr is updated on the same condition.
  - hit_k, k >= 1, with seen[k] clear: set seen[k]; increment error_num if wdata != exp[k].
  - hit_k with seen[k] already set: ignored, no error.
  - All seen bits set after an update: next cycle REPORT, timeout 0.
  - duration == TIMEOUT_CYC-1 with bits still clear: next cycle REPORT, timeout 1, error_num += popcount(~seen).
  - A final hit and timeout in the same cycle: the hit is evaluated first. If that completes the bitmap, this is a normal finish with timeout 0.
- REPORT:
  - Terminal; all outputs frozen; finish 1.
  - Leaves only by reset.
- Arithmetic: every counter, including error_num, saturates at all ones and never wraps.
- Reset mid-operation returns everything to the reset state immediately; no partial report.

Decomposition:
- Package riscv_mon_pkg:
  - monitor state enum (IDLE/CHECK/REPORT)
  - default parameter constants
  - byte-swap function
  - saturating-increment function
- One natural sub-module, sat_counter (width parameter; inputs inc, clr; saturating). Instantiated five times for duration, stall, flush, branch and instr.

Test Plan:
1. NUM_CHECKS=4, BASE_ADDR=0, exp={FFFFFFFE,2,7,1}; write bytes FEFFFFFF to addr 0, then 02000000, 07000000, 01000000 to addrs 1..3 -> REPORT, error_num 0, pass 1, timeout 0.
2. Same setup, but addr 2 receives 08000000 -> finish 1, error_num 1, pass 0.
3. wen held high for 3 stalled cycles on addr 1 -> counted once. A second write to addr 1 after wen drops is ignored -> error_num unchanged.
4. TIMEOUT_CYC=20; only ports 0 and 1 written -> REPORT at duration 20, timeout 1, error_num 2.
5. In CHECK, drive stall 5 cycles, flush 2, is_branch 3, and 4 I_addr changes (1 of them during stall) -> counters 5/2/3/3. With CNT_W=4 over 20 stalls -> stall_cycles 15 (saturated).
6. Assert rst for 1 cycle mid-CHECK -> IDLE, error_num FF, counters 0. Expected table retains its values; rerunning scenario 1 passes.
